// File: rtl/pkt_mux_rr_if.sv
// Flit bus between N input ports, pkt_mux_rr and the output link.
interface pkt_mux_rr_if #(
  parameter int NPORT = 2,
  parameter int DATAW = 67,
  parameter int VCHW  = 2,
  parameter int SELW  = 3
);
  logic [NPORT*DATAW-1:0] idata;
  logic [NPORT-1:0]       ivalid;
  logic [NPORT*VCHW-1:0]  ivch;
  logic [NPORT-1:0]       iready;
  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [DATAW-1:0]       odata;
  logic                   ovalid;
  logic [VCHW-1:0]        ovch;
  logic                   oready;
  logic                   drop;
  logic                   err;

  modport master (
    output idata, ivalid, ivch,
    output mode, sel, oready,
    input  iready, odata, ovalid,
    input  ovch, drop, err
  );

  modport slave (
    input  idata, ivalid, ivch,
    input  mode, sel, oready,
    output iready, odata, ovalid,
    output ovch, drop, err
  );
endinterface

// File: rtl/pkt_mux_rr.sv
// Packet-aware N:1 flit mux, round-robin or forced select,
// locked HEAD..TAIL, one registered output stage.
module pkt_mux_rr #(
  parameter int NPORT = 2,
  parameter int DATAW = 67,
  parameter int TYPEW = 3,
  parameter int VCHW  = 2,
  parameter int SELW  = 3
) (
  input  logic        clk,
  input  logic        rst_,
  pkt_mux_rr_if.slave bus
);
  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q;
  logic [SELW-1:0]  rr_ptr_q;
  logic [SELW-1:0]  owner_q;
  logic [DATAW-1:0] odata_q;
  logic [VCHW-1:0]  ovch_q;
  logic             ovalid_q;
  logic             drop_q;
  logic             err_q;

  logic             out_free;
  logic [NPORT-1:0] is_head;
  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] cand;
  logic [NPORT-1:0] rdy;
  logic             found;
  logic             acc;
  logic             drop_d;
  logic [SELW-1:0]  gnt;
  logic [SELW-1:0]  port;
  logic [DATAW-1:0] flit;
  logic [VCHW-1:0]  vch;

  always_comb begin
    out_free = !ovalid_q || bus.oready;
    for (int p = 0; p < NPORT; p++) begin
      is_head[p] =
        bus.idata[p*DATAW+DATAW-TYPEW +: TYPEW]
        == T_HEAD;
      elig[p] = !bus.mode
             || (bus.sel == SELW'(p));
      cand[p] = bus.ivalid[p] && is_head[p]
             && elig[p];
    end
  end

  // First HEAD candidate after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 1; k <= NPORT; k++) begin
      for (int p = 0; p < NPORT; p++) begin
        if (!found && cand[p]
            && p == (int'(rr_ptr_q) + k) % NPORT) begin
          found = 1'b1;
          gnt   = SELW'(p);
        end
      end
    end
  end

  always_comb begin
    rdy    = '0;
    drop_d = 1'b0;
    acc    = 1'b0;
    port   = owner_q;
    if (state_q == IDLE) begin
      port = gnt;
      acc  = found && out_free;
      for (int p = 0; p < NPORT; p++) begin
        if (bus.ivalid[p] && !is_head[p]
            && elig[p]) begin
          rdy[p] = 1'b1;
          drop_d = 1'b1;
        end
        if (found && SELW'(p) == gnt)
          rdy[p] = out_free;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (SELW'(p) == owner_q) begin
          rdy[p] = out_free;
          acc    = out_free && bus.ivalid[p];
        end
      end
    end
    flit = '0;
    vch  = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (SELW'(p) == port) begin
        flit = bus.idata[p*DATAW +: DATAW];
        vch  = bus.ivch[p*VCHW +: VCHW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      rr_ptr_q <= SELW'(NPORT - 1);
      owner_q  <= '0;
      odata_q  <= '0;
      ovch_q   <= '0;
      ovalid_q <= 1'b0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      drop_q <= drop_d;
      err_q  <= 1'b0;
      if (acc) begin
        odata_q  <= flit;
        ovch_q   <= vch;
        ovalid_q <= 1'b1;
      end else if (out_free) begin
        ovalid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            owner_q <= gnt;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (acc) begin
            if (flit[DATAW-1 -: TYPEW] == T_TAIL) begin
              state_q  <= IDLE;
              rr_ptr_q <= owner_q;
            end else if (flit[DATAW-1 -: TYPEW]
                         == T_HEAD) begin
              err_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.iready = rst_ ? rdy : '0;
  assign bus.odata  = odata_q;
  assign bus.ovch   = ovch_q;
  assign bus.ovalid = ovalid_q;
  assign bus.drop   = drop_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_pkt_mux_rr.sv
// Directed bench for pkt_mux_rr: 2-port and 4-port instances.
`timescale 1ns/1ps
module tb_pkt_mux_rr;
  localparam int DW = 67;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  pkt_mux_rr_if #(
    .NPORT(2), .DATAW(67), .VCHW(2), .SELW(3)
  ) b2 ();
  pkt_mux_rr_if #(
    .NPORT(4), .DATAW(67), .VCHW(2), .SELW(3)
  ) b4 ();

  pkt_mux_rr #(
    .NPORT(2), .DATAW(67), .TYPEW(3),
    .VCHW(2), .SELW(3)
  ) u2 (.clk(clk), .rst_(rst_), .bus(b2));

  pkt_mux_rr #(
    .NPORT(4), .DATAW(67), .TYPEW(3),
    .VCHW(2), .SELW(3)
  ) u4 (.clk(clk), .rst_(rst_), .bus(b4));

  int n_chk  = 0;
  int n_fail = 0;
  int errs   = 0;
  int drops  = 0;

  logic [68:0] q2 [2][$];
  logic [68:0] q4 [4][$];
  logic [68:0] e2 [$];
  logic [68:0] o2 [$];
  logic [1:0]  g4 [$];
  logic [1:0]  acc2 = '0;
  logic [3:0]  acc4 = '0;
  logic        pend2 = 1'b0;
  logic        fwd2  = 1'b1;
  logic [68:0] exp2 = '0;
  logic [66:0] held = '0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [68:0] fl(
    input logic [1:0] vc,
    input logic [2:0] ty,
    input logic [63:0] pl);
    return {vc, ty, pl};
  endfunction

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      if (q2[p].size() > 0) begin
        b2.ivalid[p] = 1'b1;
        b2.idata[p*DW +: DW] = q2[p][0][66:0];
        b2.ivch[p*2 +: 2] = q2[p][0][68:67];
      end else begin
        b2.ivalid[p] = 1'b0;
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (q4[p].size() > 0) begin
        b4.ivalid[p] = 1'b1;
        b4.idata[p*DW +: DW] = q4[p][0][66:0];
        b4.ivch[p*2 +: 2] = q4[p][0][68:67];
      end else begin
        b4.ivalid[p] = 1'b0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (pend2)
      chk("lat2", {b2.ovch, b2.odata}, exp2);
    pend2 = 1'b0;
    acc2 = b2.ivalid & b2.iready;
    acc4 = b4.ivalid & b4.iready;
    for (int p = 0; p < 2; p++) begin
      if (fwd2 && acc2[p]) begin
        exp2  = q2[p][0];
        pend2 = 1'b1;
      end
    end
    if (b2.ovalid && b2.oready)
      o2.push_back({b2.ovch, b2.odata});
    if (b4.ovalid && b4.oready
        && b4.odata[66:64] == 3'd1)
      g4.push_back(b4.ovch);
    if (b2.drop) drops++;
    if (b2.err) begin
      errs++;
      chk("err_hd", b2.odata[66:64], 3'd1);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++)
      if (acc2[p]) void'(q2[p].pop_front());
    for (int p = 0; p < 4; p++)
      if (acc4[p]) void'(q4[p].pop_front());
    acc2 = '0;
    acc4 = '0;
    drive();
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic drain2(input string tag);
    int c = 0;
    while ((q2[0].size() + q2[1].size() > 0
            || b2.ovalid) && c < 100) begin
      tick();
      c++;
    end
    chk(tag, q2[0].size() + q2[1].size(), 0);
  endtask

  task automatic cmp_out(input string tag);
    chk({tag, "_n"}, o2.size(), e2.size());
    for (int i = 0; i < e2.size(); i++)
      if (i < o2.size()) chk(tag, o2[i], e2[i]);
    o2.delete();
    e2.delete();
  endtask

  initial begin
    b2.idata = '0; b2.ivch = '0;
    b2.mode = 1'b0; b2.sel = '0;
    b2.oready = 1'b1;
    b4.idata = '0; b4.ivch = '0;
    b4.mode = 1'b0; b4.sel = '0;
    b4.oready = 1'b1; b4.ivalid = '0;
    // HEADs held during reset must not be accepted
    b2.idata[66:64] = 3'd1;
    b2.idata[133:131] = 3'd1;
    b2.ivalid = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", b2.ovalid, 0);
    chk("rst_od", b2.odata, 0);
    chk("rst_vc", b2.ovch, 0);
    chk("rst_dp", b2.drop, 0);
    chk("rst_er", b2.err, 0);
    chk("rst_rdy", b2.iready, 0);
    chk("rst_ov4", b4.ovalid, 0);
    b2.ivalid = 2'b00;
    #1;
    rst_ = 1'b1;

    // two simultaneous packets, round-robin
    for (int p = 0; p < 2; p++) begin
      logic [63:0] base;
      base = 64'hA000 + 64'(p) * 64'h1000;
      q2[p].push_back(fl(2'(p+1), 3'd1, base));
      for (int i = 1; i <= 20; i++)
        q2[p].push_back(
          fl(2'(p+1), 3'd2, base + 64'(i)));
      q2[p].push_back(
        fl(2'(p+1), 3'd3, base + 64'hFF));
    end
    for (int p = 0; p < 2; p++)
      foreach (q2[p][i]) e2.push_back(q2[p][i]);
    drive();
    begin
      int n0 = 0;
      int viol = 0;
      for (int c = 0; c < 100; c++) begin
        if (q2[0].size() + q2[1].size() == 0
            && !b2.ovalid) break;
        sample();
        if (n0 < 22 && b2.iready[1]) viol++;
        if (acc2[0]) n0++;
        adv();
      end
      chk("t1_rdy1", viol, 0);
      chk("t1_done", q2[0].size() + q2[1].size(), 0);
    end
    cmp_out("t1");

    // forced select, toggle payloads, per-flit vch
    b2.mode = 1'b1;
    b2.sel  = 3'd1;
    begin
      logic [63:0] pat [3];
      pat[0] = 64'h7FFFFFE000;
      pat[1] = 64'h0003FFFFFF;
      pat[2] = 64'h0;
      q2[1].push_back(fl(2'd3, 3'd1, 64'h04));
      for (int i = 0; i < 6; i++)
        q2[1].push_back(
          fl(2'(i), 3'd2, pat[i % 3]));
      q2[1].push_back(fl(2'd2, 3'd3, 64'h5A));
    end
    foreach (q2[1][i]) e2.push_back(q2[1][i]);
    drive();
    drain2("t2_done");
    cmp_out("t2");

    // output stall mid-packet
    b2.mode = 1'b0;
    q2[0].push_back(fl(2'd1, 3'd1, 64'hC0));
    for (int i = 1; i <= 6; i++)
      q2[0].push_back(fl(2'd1, 3'd2, 64'hC0 + 64'(i)));
    q2[0].push_back(fl(2'd1, 3'd3, 64'hCF));
    foreach (q2[0][i]) e2.push_back(q2[0][i]);
    drive();
    for (int c = 0; c < 60; c++) begin
      if (c > 8 && q2[0].size() == 0
          && !b2.ovalid) break;
      b2.oready = !(c >= 5 && c <= 7);
      sample();
      if (c == 5) held = b2.odata;
      if (c >= 5 && c <= 7) begin
        chk("stl_ov", b2.ovalid, 1);
        chk("stl_rdy", b2.iready[0], 0);
        if (c > 5) chk("stl_hold", b2.odata, held);
      end
      adv();
    end
    b2.oready = 1'b1;
    chk("t3_done", q2[0].size(), 0);
    cmp_out("t3");

    // orphan DATA in IDLE is dropped
    fwd2 = 1'b0;
    q2[0].push_back(fl(2'd1, 3'd2, 64'hDD));
    drive();
    sample();
    chk("drp_rdy", b2.iready[0], 1);
    chk("drp_ov0", b2.ovalid, 0);
    adv();
    sample();
    chk("drp_pls", b2.drop, 1);
    chk("drp_ov1", b2.ovalid, 0);
    adv();
    sample();
    chk("drp_end", b2.drop, 0);
    adv();

    // out-of-range sel: nothing granted, nothing dropped
    b2.mode = 1'b1;
    b2.sel  = 3'd3;
    q2[0].push_back(fl(2'd1, 3'd1, 64'h11));
    q2[1].push_back(fl(2'd2, 3'd2, 64'h22));
    drive();
    sample();
    chk("oob_rdy", b2.iready, 0);
    adv();
    sample();
    chk("oob_drp", b2.drop, 0);
    chk("oob_ov", b2.ovalid, 0);
    adv();
    b2.sel = 3'd1;
    #1;
    sample();
    chk("sel1_rdy", b2.iready, 2'b10);
    adv();
    sample();
    chk("sel1_drp", b2.drop, 1);
    chk("sel1_ov", b2.ovalid, 0);
    adv();
    q2[0].delete();
    b2.mode = 1'b0;
    drive();
    fwd2 = 1'b1;
    o2.delete();

    // second HEAD inside a locked packet
    errs  = 0;
    drops = 0;
    q2[1].push_back(fl(2'd2, 3'd1, 64'hE0));
    q2[1].push_back(fl(2'd2, 3'd2, 64'hE1));
    q2[1].push_back(fl(2'd2, 3'd1, 64'hE2));
    q2[1].push_back(fl(2'd2, 3'd2, 64'hE3));
    q2[1].push_back(fl(2'd2, 3'd3, 64'hE4));
    foreach (q2[1][i]) e2.push_back(q2[1][i]);
    drive();
    drain2("t5_done");
    chk("t5_err", errs, 1);
    chk("t5_drop", drops, 0);
    cmp_out("t5");

    // 4-port continuous HEAD/TAIL rotation
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 3; k++) begin
        q4[p].push_back(
          fl(2'(p), 3'd1, 64'(p * 16 + k)));
        q4[p].push_back(
          fl(2'(p), 3'd3, 64'(p * 16 + k)));
      end
    end
    drive();
    for (int c = 0; c < 100; c++) begin
      sample();
      if (g4.size() >= 6) break;
      adv();
    end
    chk("rr_n", g4.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < g4.size()) chk("rr_ord", g4[i], i % 4);

    // reset while locked on port 1
    rst_ = 1'b0;
    #1;
    chk("arst_ov", b4.ovalid, 0);
    chk("arst_rdy", b4.iready, 0);
    chk("arst_od", b4.odata, 0);
    for (int p = 0; p < 4; p++) q4[p].delete();
    for (int p = 0; p < 2; p++) q2[p].delete();
    acc2  = '0;
    acc4  = '0;
    pend2 = 1'b0;
    g4.delete();
    for (int p = 0; p < 4; p++) begin
      q4[p].push_back(fl(2'(p), 3'd1, 64'h70));
      q4[p].push_back(fl(2'(p), 3'd3, 64'h71));
    end
    drive();
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (g4.size() > 0) break;
      adv();
    end
    chk("post_n", g4.size() > 0, 1);
    if (g4.size() > 0) chk("post_gnt", g4[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_mux_rr.md
Name: pkt_mux_rr

Overview:
Parametrised, packet-aware N:1 output multiplexer for the router datapath. It is the registered successor of the combinational 2:1 flit mux. It arbitrates round-robin among NPORT input ports or follows a forced select, and locks to one port from HEAD flit to TAIL flit. It drives a one-stage registered output with a valid/ready handshake toward the output link.

Parameters:
NPORT, 2, number of input ports (2..8)
DATAW, 67, flit width in bits including type field
TYPEW, 3, type field width, located at flit bits [DATAW-1:DATAW-TYPEW]
VCHW, 2, virtual-channel id width
SELW, 3, width of forced-select index (>= clog2(NPORT))

Ports:
clk  in  1  clock, rising edge
rst_  in  1  asynchronous reset, active-low
idata  in  NPORT*DATAW  input flits, port i at [i*DATAW +: DATAW]
ivalid  in  NPORT  per-port flit valid
ivch  in  NPORT*VCHW  per-port VC id, port i at [i*VCHW +: VCHW]
iready  out  NPORT  per-port accept (combinational)
mode  in  1  0 = round-robin arbitration, 1 = forced select
sel  in  SELW  forced port index (used when mode=1)
odata  out  DATAW  registered output flit
ovalid  out  1  registered output valid
ovch  out  VCHW  registered output VC id
oready  in  1  downstream accept
drop  out  1  one-cycle pulse: non-HEAD flit discarded in IDLE
err  out  1  one-cycle pulse: HEAD accepted while LOCKED

Behaviour:
- Clock and reset: one clock (clk); reset rst_ is asynchronous, active-low.
- Type encoding: NONE=0, HEAD=1, DATA=2, TAIL=3, all other values treated as DATA.
- Reset values: ovalid=0, odata=0, ovch=0, drop=0, err=0, state=IDLE, rr_ptr=NPORT-1 (port 0 wins first), owner=0. iready=0 while rst_ low.
- Output free: out_free = !ovalid || oready.
- Transfer: a flit is accepted on port p when ivalid[p] && iready[p] at a clk edge.
- Accepted flit appears on odata/ovch with ovalid=1 the next cycle. Latency is 1 cycle.
- Output register holds odata/ovch/ovalid stable while ovalid && !oready.
- When out_free and no flit is accepted, ovalid=0 next cycle and odata keeps its last value.
- Full throughput: one flit per cycle when oready stays high.
- State IDLE:
  - Candidates: ports with ivalid=1 and type HEAD.
  - mode=0: grant the first candidate searching from rr_ptr+1 upward, wrapping modulo NPORT.
  - mode=1: candidate set is port sel only.
  - sel >= NPORT: no grant, no drop.
  - iready[g]=out_free for the granted port g only.
  - On HEAD accept: owner=g, go to LOCKED.
  - Any valid non-HEAD flit on a port eligible in the current mode (any port in mode 0, port sel in mode 1): iready=1 regardless of out_free, flit discarded, drop=1 next cycle.
  - Several drops in one cycle produce a single drop pulse.
  - A port being granted a HEAD is never dropped in the same cycle.
- State LOCKED:
  - iready[owner]=out_free; all other iready=0.
  - Accepting TAIL: return to IDLE, rr_ptr=owner.
  - Accepting HEAD: flit forwarded, err=1 next cycle, remain LOCKED.
  - DATA forwarded unchanged.
  - mode and sel are ignored; changes take effect only in IDLE.
- Simultaneous events:
  - TAIL accept and a new HEAD on another port in the same cycle: the new HEAD is not granted until the following cycle, so there is a 1 idle cycle minimum between packets.
  - Output stall (oready=0 with ovalid=1) blocks acceptance on all ports; ivalid must hold.
- Reset mid-packet: all state cleared immediately; the partial packet is lost, with no TAIL generated.
- ovch is taken from the accepting port's ivch per flit, not latched at HEAD.
- Synthesisable, no latches, no combinational path from oready to ovalid/odata.

Test Plan:
- Reset, then mode=0, port0 and port1 both present HEAD at once, 20 DATA, TAIL, oready=1 -> port0 packet (22 flits) out first, one idle cycle, then port1 packet. Each flit appears 1 cycle after acceptance, and iready[1]=0 throughout port0's packet.
- mode=1, sel=1, port1 sends HEAD with payload 0x04, DATA words cycling 39'h7FFFFFE000 / 39'h0003FFFFFF / 0, then TAIL; port0 idle -> odata matches each port1 flit exactly, ovch=ivch_1, 67% toggle pattern preserved.
- Mid-packet oready=0 for 3 cycles -> ovalid=1 and odata held constant, iready[owner]=0 for those cycles, no flit lost or duplicated after release.
- IDLE, port0 presents DATA flit with no HEAD -> iready[0]=1, drop=1 for exactly one cycle, ovalid stays 0.
- LOCKED on port1, port1 sends a second HEAD -> HEAD forwarded, err pulses once, state stays LOCKED until TAIL.
- NPORT=4, all ports loop HEAD/TAIL packets continuously -> grants in order 0,1,2,3,0; rst_ low mid-packet -> ovalid=0 asynchronously, next grant goes to port 0.
